// File: rtl/cascade_time_counter.sv
// Modulo-N time-unit counter with tick prescaler for cascaded sec/min/hour chains.
// Optional macro DOWN_COUNT_EN adds a dir port for down counting with borrow.
module cascade_time_counter #(
  parameter int WIDTH    = 7,
  parameter int MODULUS  = 60,
  parameter int PRESCALE = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef DOWN_COUNT_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] value,
  output logic             carry_out,
  output logic             load_err
);

  // One extra bit so MODULUS == 2**WIDTH still compares correctly
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] VAL_LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PRE_LAST = WIDTH'(PRESCALE - 1);

  logic [WIDTH-1:0] prescaler;
  logic             load_ok;
  logic             roll;
  logic             down;

  assign load_ok = {1'b0, load_value} < MOD_W;
  assign roll    = prescaler == PRE_LAST;

`ifdef DOWN_COUNT_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value     <= '0;
      prescaler <= '0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        if (load_ok) begin
          value     <= load_value;
          prescaler <= '0;
        end else begin
          load_err  <= 1'b1;
        end
      end else if (!hold && tick_in) begin
        if (!roll) begin
          prescaler <= prescaler + 1'b1;
        end else begin
          prescaler <= '0;
          if (down) begin
            if (value == '0) begin
              value     <= VAL_LAST;
              carry_out <= 1'b1;
            end else begin
              value     <= value - 1'b1;
            end
          end else begin
            if (value == VAL_LAST) begin
              value     <= '0;
              carry_out <= 1'b1;
            end else begin
              value     <= value + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cascade_time_counter.sv
// Bench for cascade_time_counter: directed steps plus random traffic vs. a model.
// Two instances (PRESCALE=1 and PRESCALE=60) share all inputs.
module tb_cascade_time_counter;
  localparam int W = 7;
  localparam int M = 60;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick_in;
  logic         hold;
  logic         load;
  logic [W-1:0] load_value;
  logic         dir;
  logic [W-1:0] v1, v60;
  logic         c1, c60, e1, e60;

  int n_cmp = 0;
  int n_err = 0;

  int ps [2] = '{1, 60};
  int mv [2];
  int mp [2];
  int mc [2];
  int me [2];

  always #5 clk = ~clk;

  cascade_time_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .hold(hold),
    .load(load), .load_value(load_value),
`ifdef DOWN_COUNT_EN
    .dir(dir),
`endif
    .value(v1), .carry_out(c1), .load_err(e1)
  );

  cascade_time_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(60)) u_p60 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .hold(hold),
    .load(load), .load_value(load_value),
`ifdef DOWN_COUNT_EN
    .dir(dir),
`endif
    .value(v60), .carry_out(c60), .load_err(e60)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mp[i] = 0; mc[i] = 0; me[i] = 0;
    end
  endtask

  // Reference: value/prescaler as integers, one spec rule per branch
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0;
      me[i] = 0;
      if (load) begin
        if (int'(load_value) < M) begin
          mv[i] = int'(load_value);
          mp[i] = 0;
        end else me[i] = 1;
      end else if (!hold && tick_in) begin
        mp[i] = (mp[i] + 1) % ps[i];
        if (mp[i] == 0) begin
          if (dir) begin
            mv[i] = (mv[i] + M - 1) % M;
            mc[i] = (mv[i] == M - 1) ? 1 : 0;
          end else begin
            mv[i] = (mv[i] + 1) % M;
            mc[i] = (mv[i] == 0) ? 1 : 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_v1"},  32'(v1),  32'(mv[0]));
    chk({tag, "_c1"},  32'(c1),  32'(mc[0]));
    chk({tag, "_e1"},  32'(e1),  32'(me[0]));
    chk({tag, "_v60"}, 32'(v60), 32'(mv[1]));
    chk({tag, "_c60"}, 32'(c60), 32'(mc[1]));
    chk({tag, "_e60"}, 32'(e60), 32'(me[1]));
  endtask

  task automatic step(string tag, logic t, logic h, logic l,
                      logic [W-1:0] lv);
    tick_in    = t;
    hold       = h;
    load       = l;
    load_value = lv;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; tick_in = 1'b0; hold = 1'b0;
    load = 1'b0; load_value = '0; dir = 1'b0;
    model_reset();

    // reset with tick toggling
    for (int i = 0; i < 4; i++) begin
      tick_in = ~tick_in;
      @(posedge clk);
      #1;
      check_all("rst");
    end
    reset = 1'b0;
    step("rst_rel", 1'b0, 1'b0, 1'b0, '0);
    chk("rst_rel_v1", 32'(v1), 32'd0);

    // wrap at MODULUS with PRESCALE=1
    step("t2_ld", 1'b0, 1'b0, 1'b1, 7'd58);
    step("t2_a", 1'b1, 1'b0, 1'b0, '0);
    chk("t2_v59", 32'(v1), 32'd59);
    chk("t2_c0", 32'(c1), 32'd0);
    step("t2_b", 1'b1, 1'b0, 1'b0, '0);
    chk("t2_wrap", 32'(v1), 32'd0);
    chk("t2_carry", 32'(c1), 32'd1);
    step("t2_c", 1'b0, 1'b0, 1'b0, '0);
    chk("t2_carry_once", 32'(c1), 32'd0);

    // prescaler of 60
    step("t3_ld", 1'b0, 1'b0, 1'b1, 7'd0);
    for (int i = 0; i < 119; i++) step("t3", 1'b1, 1'b0, 1'b0, '0);
    chk("t3_v1", 32'(v60), 32'd1);
    step("t3_120", 1'b1, 1'b0, 1'b0, '0);
    chk("t3_v2", 32'(v60), 32'd2);
    chk("t3_nc", 32'(c60), 32'd0);

    // out-of-range load with a tick in the same cycle
    step("t4_ld", 1'b1, 1'b0, 1'b1, 7'd60);
    chk("t4_err", 32'(e1), 32'd1);
    chk("t4_v", 32'(v60), 32'd2);
    step("t4_b", 1'b0, 1'b0, 1'b0, '0);
    chk("t4_err_once", 32'(e1), 32'd0);
    step("t4_max", 1'b0, 1'b0, 1'b1, 7'd127);
    chk("t4_err127", 32'(e60), 32'd1);

    // hold at 59, then release
    step("t5_ld", 1'b0, 1'b0, 1'b1, 7'd59);
    for (int i = 0; i < 10; i++) step("t5_h", 1'b1, 1'b1, 1'b0, '0);
    chk("t5_held", 32'(v1), 32'd59);
    step("t5_go", 1'b1, 1'b0, 1'b0, '0);
    chk("t5_wrap", 32'(v1), 32'd0);
    chk("t5_carry", 32'(c1), 32'd1);

`ifdef DOWN_COUNT_EN
    step("t6_ld", 1'b0, 1'b0, 1'b1, 7'd0);
    dir = 1'b1;
    step("t6", 1'b1, 1'b0, 1'b0, '0);
    chk("t6_borrow_v", 32'(v1), 32'd59);
    chk("t6_borrow_c", 32'(c1), 32'd1);
    dir = 1'b0;
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
`ifdef DOWN_COUNT_EN
      dir = 1'($urandom_range(0, 1));
`endif
      step("rnd",
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 29) == 0,
           W'($urandom_range(0, 127)));
    end

    // asynchronous reset mid-cycle
    step("pre_ar", 1'b0, 1'b0, 1'b1, 7'd59);
    step("pre_ar2", 1'b1, 1'b0, 1'b0, '0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step("post_ar", 1'b0, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
